// File: rtl/present_pkg.sv
// Shared definitions for the PRESENT key schedule: the S-boxes, the key-width
// constants, the FSM state type and the round-counter width.
package present_pkg;

    localparam int unsigned KEY_80  = 80;
    localparam int unsigned KEY_128 = 128;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned RK_W    = 64;

    typedef enum logic [1:0] {
        IDLE,
        PRECOMP,
        EMIT
    } state_t;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;
            4'h1: y = 4'hE;
            4'h2: y = 4'hF;
            4'h3: y = 4'h8;
            4'h4: y = 4'hC;
            4'h5: y = 4'h1;
            4'h6: y = 4'h2;
            4'h7: y = 4'hD;
            4'h8: y = 4'hB;
            4'h9: y = 4'h4;
            4'hA: y = 4'h6;
            4'hB: y = 4'h3;
            4'hC: y = 4'h0;
            4'hD: y = 4'h7;
            4'hE: y = 4'h9;
            default: y = 4'hA;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/present_key_step.sv
// Combinational single PRESENT key-register update, forward or inverse,
// for 80- or 128-bit keys.
module present_key_step
    import present_pkg::*;
#(
    parameter int unsigned KEY_WIDTH = KEY_80
) (
    input  logic [KEY_WIDTH-1:0] k,
    input  logic [CNT_W-1:0]     i,
    input  logic                 inv,
    output logic [KEY_WIDTH-1:0] k_next
);

    localparam int unsigned XLSB = (KEY_WIDTH == KEY_128) ? 62 : 15;

    logic [KEY_WIDTH-1:0] t;

    always_comb begin
        t      = '0;
        k_next = '0;
        if (!inv) begin
            t = {k[KEY_WIDTH-62:0], k[KEY_WIDTH-1:KEY_WIDTH-61]};
            t[KEY_WIDTH-1 -: 4] = sbox(t[KEY_WIDTH-1 -: 4]);
            if (KEY_WIDTH == KEY_128) begin
                t[KEY_WIDTH-5 -: 4] = sbox(t[KEY_WIDTH-5 -: 4]);
            end
            t[XLSB +: CNT_W] = t[XLSB +: CNT_W] ^ i;
            k_next = t;
        end else begin
            // Undo the forward steps in reverse order: XOR, S-box, rotation.
            t = k;
            t[XLSB +: CNT_W] = t[XLSB +: CNT_W] ^ i;
            t[KEY_WIDTH-1 -: 4] = sbox_inv(t[KEY_WIDTH-1 -: 4]);
            if (KEY_WIDTH == KEY_128) begin
                t[KEY_WIDTH-5 -: 4] = sbox_inv(t[KEY_WIDTH-5 -: 4]);
            end
            k_next = {t[60:0], t[KEY_WIDTH-1:61]};
        end
    end

endmodule

// File: rtl/present_key_schedule.sv
// PRESENT round-key generator: streams ROUNDS+1 round keys over valid/ready,
// in forward order or, after a precompute pass, in reverse order.
module present_key_schedule
    import present_pkg::*;
#(
    parameter int unsigned KEY_WIDTH = KEY_80,
    parameter int unsigned ROUNDS    = 31
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [KEY_WIDTH-1:0] key_in,
    input  logic                 dir,
    input  logic                 key_valid,
    output logic                 key_ready,
    output logic [RK_W-1:0]      rk_out,
    output logic [CNT_W-1:0]     rk_round,
    output logic                 rk_valid,
    input  logic                 rk_ready,
    output logic                 rk_last,
    output logic                 busy
);

    if (KEY_WIDTH != KEY_80 && KEY_WIDTH != KEY_128) begin : g_bad_width
        $error("present_key_schedule: KEY_WIDTH must be 80 or 128");
    end
    if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
        $error("present_key_schedule: ROUNDS must be in 1..31");
    end

    // One spare counter bit so index ROUNDS+1 (32 at most) is distinct from 0;
    // rk_round shows the low 5 bits.
    localparam int unsigned CW = CNT_W + 1;
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_ROUNDS = CW'(ROUNDS);
    localparam logic [CW-1:0] CNT_LAST   = CW'(ROUNDS + 1);

    state_t               state, state_next;
    logic [KEY_WIDTH-1:0] key_reg, key_next, k_step;
    logic [CW-1:0]        cnt, cnt_next, cnt_inc, cnt_dec;
    logic                 dir_r, dir_next;
    logic [CNT_W-1:0]     step_i;
    logic                 step_inv;

    assign cnt_inc  = cnt + CNT_ONE;
    assign cnt_dec  = cnt - CNT_ONE;
    assign step_inv = (state == EMIT) && dir_r;
    assign step_i   = step_inv ? cnt_dec[CNT_W-1:0] : cnt[CNT_W-1:0];

    present_key_step #(
        .KEY_WIDTH(KEY_WIDTH)
    ) u_step (
        .k      (key_reg),
        .i      (step_i),
        .inv    (step_inv),
        .k_next (k_step)
    );

    assign key_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign rk_valid  = (state == EMIT);
    assign rk_out    = key_reg[KEY_WIDTH-1 -: RK_W];
    assign rk_round  = cnt[CNT_W-1:0];
    assign rk_last   = (state == EMIT) && (dir_r ? (cnt == CNT_ONE) : (cnt == CNT_LAST));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            key_reg <= '0;
            cnt     <= '0;
            dir_r   <= 1'b0;
        end else begin
            state   <= state_next;
            key_reg <= key_next;
            cnt     <= cnt_next;
            dir_r   <= dir_next;
        end
    end

    always_comb begin
        state_next = state;
        key_next   = key_reg;
        cnt_next   = cnt;
        dir_next   = dir_r;
        case (state)
            IDLE: begin
                if (key_valid) begin
                    key_next   = key_in;
                    dir_next   = dir;
                    cnt_next   = CNT_ONE;
                    state_next = dir ? PRECOMP : EMIT;
                end
            end
            PRECOMP: begin
                key_next = k_step;
                if (cnt == CNT_ROUNDS) begin
                    cnt_next   = CNT_LAST;
                    state_next = EMIT;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            EMIT: begin
                if (rk_ready) begin
                    if (rk_last) begin
                        state_next = IDLE;
                    end else begin
                        key_next = k_step;
                        cnt_next = dir_r ? cnt_dec : cnt_inc;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
